// File: rtl/cordic_cos_core.sv
// Iterative rotation-mode CORDIC producing unsigned Q1.FRACS cos(angle) for angles clamped to [-1,1] rad.
// Build option: define CORDIC_ROUND_EN to round (half-up) instead of truncate when dropping the guard bits.
module cordic_cos_core #(
  parameter int FRACS = 22,
  parameter int INTS  = 1,
  parameter int ITERS = 24,
  parameter int GUARD = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FRACS+1:0]        in_angle,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INTS+FRACS-1:0]   out_data,
  output logic                    busy
);

  localparam int FW = FRACS + GUARD;
  localparam int W  = FW + 3;
  localparam int AW = FRACS + 2;
  localparam int OW = INTS + FRACS;
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef logic signed [W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  if (INTS != 1) begin : g_ints_check
    $error("cordic_cos_core: only INTS=1 is supported");
  end
  if (ITERS < 1 || ITERS > 32) begin : g_iters_check
    $error("cordic_cos_core: ITERS must be 1..32");
  end

  function automatic logic [ITERS*W-1:0] build_atan();
    logic [ITERS*W-1:0] tab;
    tab = '0;
    for (int k = 0; k < ITERS; k++)
      tab[k*W +: W] = W'($rtoi($atan(2.0 ** (-k)) * (2.0 ** FW) + 0.5));
    return tab;
  endfunction

  localparam logic [ITERS*W-1:0] ATAN_TAB = build_atan();
  localparam word_t K_INIT = W'($rtoi(0.6072529350 * (2.0 ** FW) + 0.5));
  localparam logic signed [AW-1:0] ONE_A = AW'(1) << FRACS;
  localparam logic signed [AW-1:0] NEG_ONE_A = -ONE_A;
  localparam word_t ONE_W = word_t'(1) <<< FRACS;

  function automatic word_t clamp_angle(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] c;
    word_t ext;
    if (a > ONE_A)
      c = ONE_A;
    else if (a < NEG_ONE_A)
      c = NEG_ONE_A;
    else
      c = a;
    ext = W'(c);
    return ext <<< GUARD;
  endfunction

  function automatic word_t drop_guard(input word_t v);
`ifdef CORDIC_ROUND_EN
    return (v + (word_t'(1) <<< (GUARD - 1))) >>> GUARD;
`else
    return v >>> GUARD;
`endif
  endfunction

  // Anything at or above 1.0 is presented as exactly 1.0; negatives floor at 0.
  function automatic logic [OW-1:0] sat_out(input word_t v);
    if (v < 0)
      return '0;
    else if (v >= ONE_W)
      return OW'(ONE_W);
    else
      return v[OW-1:0];
  endfunction

  state_t          state;
  logic [CW-1:0]   iter;
  word_t           x, y, z;
  word_t           x_shr, y_shr, atan_i;
  word_t           x_nxt, y_nxt, z_nxt;
  logic signed [AW-1:0] angle_s;

  assign angle_s   = in_angle;
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // One micro-rotation: direction follows the sign of the residual angle.
  always_comb begin
    x_shr  = x >>> iter;
    y_shr  = y >>> iter;
    atan_i = word_t'(ATAN_TAB[iter*W +: W]);
    if (z >= 0) begin
      x_nxt = x - y_shr;
      y_nxt = y + x_shr;
      z_nxt = z - atan_i;
    end else begin
      x_nxt = x + y_shr;
      y_nxt = y - x_shr;
      z_nxt = z + atan_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      iter     <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= K_INIT;
            y     <= '0;
            z     <= clamp_angle(angle_s);
            iter  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          x    <= x_nxt;
          y    <= y_nxt;
          z    <= z_nxt;
          iter <= iter + CW'(1);
          if (iter == CW'(ITERS - 1)) begin
            out_data <= sat_out(drop_guard(x_nxt));
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_cos_core.sv
// Bench for cordic_cos_core: directed corner cases plus a random sweep checked against real-valued cos().
module tb_cordic_cos_core;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_angle;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_data;
  logic        busy;

  int n_vec;
  int n_bad;

  cordic_cos_core #(.FRACS(22), .INTS(1), .ITERS(24), .GUARD(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_angle(in_angle), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Real-valued cosine of the clamped angle, rounded to Q1.22.
  function automatic int ref_cos(input logic [23:0] a);
    real r;
    r = $itor($signed(a)) / 4194304.0;
    if (r > 1.0) r = 1.0;
    if (r < -1.0) r = -1.0;
    return $rtoi($cos(r) * 4194304.0 + 0.5);
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Drives one angle, waits (bounded) for the result and consumes it. lat=-1 on timeout.
  task automatic send(input logic [23:0] a, output logic [22:0] res, output int lat);
    int n;
    @(negedge clk);
    in_angle = a;
    in_valid = 1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_data;
    if (!out_valid) lat = -1;
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n  = 0;
    in_valid = 1;
    in_angle = 24'h200000;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 23'h0) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b busy=%b vld=%b data=%h, required 1 0 0 000000",
               in_ready, busy, out_valid, out_data);
    end
    @(negedge clk);
    in_valid = 0;
    reset_n  = 1;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_known_angles();
    logic [22:0] r_pos, r_neg, r_half, r_zero;
    int lat;
    send(24'h000000, r_zero, lat);
    n_vec++;
    if (lat !== 24) begin
      n_bad++;
      $display("FAIL zero_latency: got %0d cycles, required 24", lat);
    end
    n_vec++;
    if (!(r_zero == 23'h400000 || r_zero >= 23'h3FFFFC)) begin
      n_bad++;
      $display("FAIL zero_value: got %h, required 400000 or >=3FFFFC", r_zero);
    end
    send(24'h400000, r_pos, lat);
    n_vec++;
    if (absdiff(int'(r_pos), ref_cos(24'h400000)) > 4) begin
      n_bad++;
      $display("FAIL plus_one: got %h, required %h +-4", r_pos, ref_cos(24'h400000));
    end
    send(24'hC00000, r_neg, lat);
    n_vec++;
    if (absdiff(int'(r_neg), int'(r_pos)) > 1) begin
      n_bad++;
      $display("FAIL minus_one_sym: got %h, required %h +-1", r_neg, r_pos);
    end
    send(24'h200000, r_half, lat);
    n_vec++;
    if (absdiff(int'(r_half), ref_cos(24'h200000)) > 4) begin
      n_bad++;
      $display("FAIL half: got %h, required %h +-4", r_half, ref_cos(24'h200000));
    end
  endtask

  task automatic test_clamp();
    logic [22:0] r_ref, r_clamp;
    int lat;
    send(24'h400000, r_ref, lat);
    send(24'h600000, r_clamp, lat);
    n_vec++;
    if (r_clamp !== r_ref) begin
      n_bad++;
      $display("FAIL clamp_pos: got %h, required %h", r_clamp, r_ref);
    end
    send(24'hC00000, r_ref, lat);
    send(24'hA00000, r_clamp, lat);
    n_vec++;
    if (r_clamp !== r_ref) begin
      n_bad++;
      $display("FAIL clamp_neg: got %h, required %h", r_clamp, r_ref);
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] held;
    int lat;
    @(negedge clk);
    in_angle = 24'h300000;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    held = out_data;
    n_vec++;
    if (absdiff(int'(held), ref_cos(24'h300000)) > 4) begin
      n_bad++;
      $display("FAIL hold_value: got %h, required %h +-4", held, ref_cos(24'h300000));
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_stable: cyc %0d vld=%b data=%h rdy=%b busy=%b, required 1 %h 0 1",
                 k, out_valid, out_data, in_ready, busy, held);
      end
    end
    @(negedge clk);
    out_ready = 1;
    in_valid  = 1;
    in_angle  = 24'hE00000;
    @(posedge clk); #1;
    out_ready = 0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL release_idle: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept: busy=%b rdy=%b, required 1 0", busy, in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== 24 || absdiff(int'(out_data), ref_cos(24'hE00000)) > 4) begin
      n_bad++;
      $display("FAIL b2b_result: lat=%0d data=%h, required 24 %h +-4", lat, out_data, ref_cos(24'hE00000));
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset_mid_run();
    logic [22:0] r;
    int lat;
    @(negedge clk);
    in_angle = 24'h100000;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 0;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 23'h0) begin
      n_bad++;
      $display("FAIL mid_reset: rdy=%b busy=%b vld=%b data=%h, required 1 0 0 000000",
               in_ready, busy, out_valid, out_data);
    end
    @(negedge clk);
    reset_n = 1;
    send(24'h200000, r, lat);
    n_vec++;
    if (lat !== 24 || absdiff(int'(r), ref_cos(24'h200000)) > 4) begin
      n_bad++;
      $display("FAIL after_reset: lat=%0d data=%h, required 24 %h +-4", lat, r, ref_cos(24'h200000));
    end
  endtask

  task automatic test_random_sweep();
    logic [22:0] r, rn;
    logic [23:0] a;
    int lat, v, e;
    real err_sum;
    err_sum = 0.0;
    for (int k = 0; k < 1000; k++) begin
      v = int'($urandom_range(0, 8388608)) - 4194304;
      a = v[23:0];
      send(a, r, lat);
      e = absdiff(int'(r), ref_cos(a));
      err_sum += $itor(e);
      n_vec++;
      if (lat !== 24 || e > 4) begin
        n_bad++;
        $display("FAIL sweep: angle=%h lat=%0d data=%h, required 24 %h +-4", a, lat, r, ref_cos(a));
      end
      if (k < 20) begin
        send(-a, rn, lat);
        n_vec++;
        if (absdiff(int'(rn), int'(r)) > 1) begin
          n_bad++;
          $display("FAIL even_sym: angle=%h got %h, required %h +-1", a, rn, r);
        end
      end
    end
    $display("sweep mean abs error = %f LSB", err_sum / 1000.0);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset_n   = 0;
    in_valid  = 0;
    in_angle  = '0;
    out_ready = 0;
    test_reset();
    test_known_angles();
    test_clamp();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
